// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter: state encoding,
// lock timeout default and byte-lane extraction from packed request data.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int LOCK_TIMEOUT_DEFAULT = 1024;

  // Requesters are limited to eight, so 64 bits covers every lane.
  function automatic logic [7:0] byte_lane(input logic [63:0] data, input int idx);
    return data[8*idx +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority finder: first set bit of valid at or
// above ptr, wrapping modulo NREQ.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  // Scan from the farthest candidate down so the one nearest ptr wins last.
  always_comb begin
    idx   = '0;
    found = |valid;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = valid[(int'(ptr) + k) % NREQ] ? IDW'((int'(ptr) + k) % NREQ) : idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide TX port among NREQ requesters.
// Define UART_ARB_LOCK_EN to keep multi-byte messages from interleaving.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int IDW          = 2,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_req,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [IDW-1:0]    grant_id,
  output logic              busy
);

  state_t          state_r;
  logic [IDW-1:0]  rr_ptr_r;
  logic            last_r;
  logic [IDW-1:0]  pick_s;
  logic            found_s;
  logic [63:0]     req_data_ext_s;

  assign req_data_ext_s = 64'(req_data);

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g);
    return (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
  endfunction

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_r),
    .idx   (pick_s),
    .found (found_s)
  );

`ifdef UART_ARB_LOCK_EN
  logic [15:0] idle_cnt_r;
`else
  logic unused_s;
  assign unused_s = ^{req_last, last_r};
`endif

  // Acceptance strobe: only while a byte can be taken into the holding register.
  always_comb begin
    req_ready = '0;
    case (state_r)
      IDLE: begin
        if (found_s) req_ready[pick_s] = 1'b1;
        else         req_ready = '0;
      end
`ifdef UART_ARB_LOCK_EN
      LOCKED: begin
        if (req_valid[grant_id]) req_ready[grant_id] = 1'b1;
        else                     req_ready = '0;
      end
`endif
      default: req_ready = '0;
    endcase
  end

  // Arbitration FSM with registered TX port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      rr_ptr_r <= '0;
      last_r   <= 1'b0;
      tx_req   <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= '0;
      busy     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      idle_cnt_r <= 16'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            tx_data  <= byte_lane(req_data_ext_s, int'(pick_s));
            tx_req   <= 1'b1;
            grant_id <= pick_s;
            last_r   <= req_last[pick_s];
            busy     <= 1'b1;
            state_r  <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_req <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            if (last_r) begin
              rr_ptr_r <= next_ptr(grant_id);
              busy     <= 1'b0;
              state_r  <= IDLE;
            end else begin
              idle_cnt_r <= 16'd0;
              state_r    <= LOCKED;
            end
`else
            rr_ptr_r <= next_ptr(grant_id);
            busy     <= 1'b0;
            state_r  <= IDLE;
`endif
          end
        end
`ifdef UART_ARB_LOCK_EN
        LOCKED: begin
          if (req_valid[grant_id]) begin
            tx_data    <= byte_lane(req_data_ext_s, int'(grant_id));
            tx_req     <= 1'b1;
            last_r     <= req_last[grant_id];
            idle_cnt_r <= 16'd0;
            state_r    <= SEND;
          end else if (idle_cnt_r == 16'(LOCK_TIMEOUT - 1)) begin
            // Owner went silent mid-message: release so others are not starved.
            rr_ptr_r <= next_ptr(grant_id);
            busy     <= 1'b0;
            state_r  <= IDLE;
          end else begin
            idle_cnt_r <= idle_cnt_r + 16'd1;
          end
        end
`endif
        default: begin
          tx_req  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=3); the lock
// scenarios run only when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int n;
  logic [7:0] got_q [6];
  logic [7:0] exp_q [6];

  uart_tx_arbiter #(.NREQ(3), .IDW(2), .LOCK_TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 3'b000;
    req_last  = 3'b000;
    tx_ready  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    req_valid = 3'b000;
    req_data  = 24'h000000;
    req_last  = 3'b000;
    tx_ready  = 1'b0;

    // Reset values
    #7;
    check_eq("rst_tx_req", tx_req, 1'b0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_grant", grant_id, 2'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", req_ready, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // Single byte from requester 1
    @(negedge clk);
    req_valid = 3'b010;
    req_data  = 24'h004100;
    tx_ready  = 1'b1;
    #1 check_eq("single_ready", req_ready, 3'b010);
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    check_eq("single_tx_req", tx_req, 1'b1);
    check_eq("single_tx_data", tx_data, 8'h41);
    check_eq("single_grant", grant_id, 2'd1);
    check_eq("single_busy", busy, 1'b1);
    check_eq("single_ready_send", req_ready, 3'b000);
    @(negedge clk);
    #1;
    check_eq("single_tx_req_end", tx_req, 1'b0);
    check_eq("single_busy_end", busy, 1'b0);

`ifndef UART_ARB_LOCK_EN
    // Fairness: all valid, strict rotation per byte
    do_reset();
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h30, 8'h31, 8'h32};
    req_data  = 24'h323130;
    req_valid = 3'b111;
    tx_ready  = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      @(negedge clk);
      #1;
      if (tx_req) begin
        got_q[n] = tx_data;
        n++;
      end
    end
    req_valid = 3'b000;
    check_eq("fair_count", n, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < n) check_eq($sformatf("fair_byte%0d", i), got_q[i], exp_q[i]);
    end
`endif

    // Backpressure: byte held stable, other requester blocked
    do_reset();
    req_valid = 3'b001;
    req_data  = 24'h000055;
    tx_ready  = 1'b0;
    #1 check_eq("bp_accept", req_ready, 3'b001);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_valid = 3'b010;
        req_data  = 24'h006655;
      end
      #1 check_eq("bp_hold", {tx_req, tx_data, req_ready}, {1'b1, 8'h55, 3'b000});
    end
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    #1;
    check_eq("bp_done_tx_req", tx_req, 1'b0);
    check_eq("bp_next_ready", req_ready, 3'b010);
    @(negedge clk);
    tx_ready  = 1'b0;
    req_valid = 3'b000;
    #1;
    check_eq("bp_next_data", tx_data, 8'h66);
    check_eq("bp_next_grant", grant_id, 2'd1);
    check_eq("bp_next_tx_req", tx_req, 1'b1);

    // Asynchronous reset while in SEND
    #1 rst = 1'b1;
    #1;
    check_eq("arst_tx_req", tx_req, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_tx_data", tx_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 3'b111;
    req_data  = 24'h323130;
    #1 check_eq("arst_ptr0", req_ready, 3'b001);
    @(negedge clk);
    req_valid = 3'b000;

`ifdef UART_ARB_LOCK_EN
    // Lock: req0 sends "AB" while req1 waits with 5A
    begin
      int k0;
      logic hit0;
      do_reset();
      exp_q = '{8'h41, 8'h42, 8'h5A, 8'h00, 8'h00, 8'h00};
      tx_ready = 1'b1;
      k0 = 0;
      n  = 0;
      for (int i = 0; i < 40 && n < 3; i++) begin
        @(negedge clk);
        req_valid = {1'b0, 1'b1, k0 < 2};
        req_last  = {1'b0, 1'b1, k0 == 1};
        req_data  = {8'h00, 8'h5A, (k0 == 0) ? 8'h41 : 8'h42};
        #1;
        if (tx_req) begin
          got_q[n] = tx_data;
          n++;
        end
        hit0 = req_ready[0];
        @(posedge clk);
        if (hit0) k0++;
      end
      req_valid = 3'b000;
      check_eq("lock_count", n, 3);
      for (int i = 0; i < 3; i++) begin
        if (i < n) check_eq($sformatf("lock_byte%0d", i), got_q[i], exp_q[i]);
      end
    end

    // Lock timeout: req0 sends one unterminated byte, then goes idle
    begin
      int locked_n;
      logic rel;
      do_reset();
      tx_ready  = 1'b1;
      req_valid = 3'b001;
      req_last  = 3'b010;
      req_data  = 24'h005A41;
      #1 check_eq("to_accept", req_ready, 3'b001);
      locked_n = 0;
      rel = 1'b0;
      for (int i = 0; i < 60 && !rel; i++) begin
        @(negedge clk);
        if (i == 0) req_valid = 3'b010;
        #1;
        if (!busy) rel = 1'b1;
        else if (!tx_req) locked_n++;
      end
      check_eq("to_released", rel, 1'b1);
      check_eq("to_locked_cycles", locked_n, 16);
      check_eq("to_ready1", req_ready, 3'b010);
      @(negedge clk);
      req_valid = 3'b000;
      #1;
      check_eq("to_data", tx_data, 8'h5A);
      check_eq("to_grant", grant_id, 2'd1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single byte-wide serial TX port (tx_req / tx_ready / tx_data) between NREQ on-chip requesters, such as the CPU console, debug monitor and trace unit.
- Uses round-robin arbitration with a one-byte holding register.
- Optional packet locking keeps multi-byte messages from interleaving on the console.
- Sits between the requesters and the RS-232 transmitter; also drives the simulation serial model in testbenches.

Parameters:
- NREQ, 3, number of requesters (2..8)
- IDW, 2, width of grant_id; must equal ceil(log2(NREQ)), minimum 1
- LOCK_TIMEOUT, 1024, idle cycles before a held lock is force-released (used only with UART_ARB_LOCK_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i has a byte
- req_data  in  8*NREQ  byte of requester i, in bits [8i+7:8i]
- req_last  in  NREQ  byte is the final byte of a message
- req_ready  out  NREQ  byte of requester i accepted this cycle (combinational)
- tx_req  out  1  send request to the transmitter (registered)
- tx_data  out  8  byte to send (registered, stable while tx_req=1)
- tx_ready  in  1  transmitter idle; a byte is taken at a posedge with tx_req & tx_ready
- grant_id  out  IDW  index of the last granted requester
- busy  out  1  holding register full or lock held

Behaviour:
- Reset values: state IDLE, tx_req=0, tx_data=8'h00, grant_id=0, rr_ptr=0, busy=0, req_ready=0.
- Reset asserted mid-transfer aborts immediately; the held byte is dropped.
- States:
  - IDLE: if any req_valid, select the first set bit searching from rr_ptr upward with wrap-around (mod NREQ). Assert req_ready[g]=1 for that cycle only. At the edge: tx_data<=req_data[g], tx_req<=1, grant_id<=g, last_q<=req_last[g], go to SEND. With no valid, stay in IDLE.
  - SEND: hold tx_req=1 and tx_data stable. At the edge where tx_ready=1: tx_req<=0.
    - Lock off, or last_q=1: rr_ptr<=(g+1) mod NREQ, go to IDLE.
    - Otherwise: go to LOCKED.
  - LOCKED (feature only): only requester grant_id may be accepted; others see req_ready=0. Acceptance works as in IDLE with g=grant_id.
- req_ready is never asserted in SEND, so at most one byte is in flight.
- Latency: a byte accepted at cycle t gives tx_req=1 from t+1. If tx_ready=1 at t+1, it transfers at t+1 and tx_req=0 at t+2. The next acceptance can occur at t+2, so minimum spacing is 2 cycles per byte.
- tx_ready low in SEND: wait indefinitely.
- tx_ready is not sampled outside SEND.
- Simultaneous valid from all requesters: strict rotation, e.g. 0,1,2,0,…
- rr_ptr advances only on message end (or on every byte without the feature).
- NREQ=1: the arbiter degenerates to a pass-through register stage.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- Defined:
  - A byte with req_last=0 locks the grant to that requester until its req_last=1 byte is sent.
  - A 16-bit idle counter counts LOCKED cycles with req_valid[grant_id]=0 and resets on each acceptance.
  - When the counter reaches LOCK_TIMEOUT, the lock is released: rr_ptr<=grant_id+1, go to IDLE.
- Undefined:
  - req_last is ignored and the LOCKED state and counter are absent.
  - Arbitration happens per byte, with rr_ptr advancing after every byte.

Decomposition:
- Package uart_arb_pkg contains:
  - the state encoding (IDLE=2'd0, SEND=2'd1, LOCKED=2'd2)
  - the LOCK_TIMEOUT default
  - a function for byte-lane extraction from the packed req_data
- One sub-module, rr_pick: a combinational round-robin priority finder (inputs valid vector and rr_ptr; outputs index and found).

Test Plan:
- Single byte: req_valid=3'b010, req_data lane1=8'h41, tx_ready=1 → req_ready=3'b010 for one cycle; tx_req=1 with tx_data=8'h41 for exactly one cycle; grant_id=1.
- Fairness (lock off): all three valid continuously with lanes 8'h30/8'h31/8'h32, tx_ready always 1 → output sequence 30,31,32,30,31,32.
- Backpressure: tx_ready held 0 for 50 cycles after acceptance → tx_req and tx_data=8'h55 held stable all 50 cycles; a second requester gets no req_ready until the transfer completes.
- Lock (UART_ARB_LOCK_EN): req0 sends "AB" (last on B) while req1 is valid throughout with 8'h5A → output order 41,42,5A.
- Lock timeout: req0 sends 8'h41 with last=0, then goes idle; req1 valid → after LOCK_TIMEOUT=16 idle cycles, req1's byte is accepted and busy briefly drops.
- Async reset: rst asserted in SEND with tx_req=1 → tx_req=0 and busy=0 immediately (before the next clock edge); after release, the next request starts from rr_ptr=0.
